firebird7_in_ijtag_scan_driver: RTL
===================================

Name: firebird7_in_ijtag_scan_driver

Overview:
- IJTAG initiator for the firebird7_in instrument network; the driving end of the sel/ce/se/ue/si/so protocol that the SIBs and TDRs respond to.
- Accepts scan commands over a valid/ready interface in the ijtag_tck domain.
- Runs one capture-shift-update sequence per command and returns the bits shifted out of the network.
- Used as the on-chip or bench-side master for a firebird7_in network segment.

Parameters:
- MAX_LEN, 64, maximum scan length in bits; cmd_data and rsp_data width.
- LEN_W, $clog2(MAX_LEN+1), width of cmd_len.
- RST_CYCLES, 4, tck cycles ijtag_net_reset_n is held low by a RESET command (feature only).

Ports:
- ijtag_tck  input  1  network test clock; FSM on posedge, output stage on negedge.
- ijtag_reset  input  1  reset ijtag_reset, asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  driver accepts a command.
- cmd_op  input  1  0=SCAN, 1=RESET (feature only).
- cmd_len  input  LEN_W  scan length in bits, 0..MAX_LEN.
- cmd_data  input  MAX_LEN  shift-in data; bit 0 is shifted first.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed.
- rsp_data  output  MAX_LEN  captured so bits; bit i is the i-th bit out; bits at index >= len are 0.
- rsp_err  output  1  command rejected; no network activity occurred.
- ijtag_sel  output  1  network select.
- ijtag_ce  output  1  capture enable.
- ijtag_se  output  1  shift enable.
- ijtag_ue  output  1  update enable.
- ijtag_si  output  1  scan data to the network.
- ijtag_so  input  1  scan data from the network (retimed by the responders, stable while tck is high).
- ijtag_net_reset_n  output  1  network reset, active-low.

Behaviour:
- Reset values: all ijtag_* outputs 0 except ijtag_net_reset_n=1; cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0.
- Mid-operation reset: sequence aborts, FSM returns to IDLE, no response is produced.
- Output timing:
  - FSM registers are on posedge. sel/ce/se/ue/si/net_reset_n are re-registered on negedge from the FSM decode.
  - Each control value is therefore stable across the following posedge (responder capture/shift) and the following negedge (responder update latch).
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready at a posedge:
    - op=SCAN, len<=MAX_LEN -> CAP. Latch len, load shift register from cmd_data, clear capture register.
    - len>MAX_LEN, or op=RESET without the feature -> RESP with rsp_err=1.
    - op=RESET with the feature -> NRST.
  - CAP: one cycle; decode sel=1, ce=1. Then -> SHIFT if len>0, else -> UPD.
  - SHIFT: len cycles; decode sel=1, se=1, si=shift_reg[0]. Shift register moves right each cycle; the counter decrements. At the last count -> UPD.
  - UPD: one cycle; decode sel=1, ue=1. Then -> RESP.
  - NRST: RST_CYCLES cycles; decode net_reset_n=0, all other controls 0. Then -> RESP with rsp_err=0 and rsp_data=0.
  - RESP: rsp_valid=1, cmd_ready=0. rsp_data and rsp_err are held stable until rsp_valid&rsp_ready at a posedge, then -> IDLE.
- so sampling:
  - At every posedge where the registered ijtag_se output is 1, so is written into capture position k (k = 0,1,...).
  - Exactly len samples are taken. The count is tracked off the registered se, not the FSM state, so there is no half-cycle skew.
- Back-to-back commands:
  - The earliest a new command can be accepted is the posedge after the response handshake.
  - Between commands, sel/ce/se/ue are 0 for at least one full tck.
- cmd_ready and rsp_valid are never both 1.
- Inputs other than cmd_valid are ignored when cmd_ready=0.

Optional Feature:
- Macro: FIREBIRD7_IN_IJTAG_DRV_NET_RESET_EN.
- Defined: op=RESET drives ijtag_net_reset_n low for RST_CYCLES tck cycles via the NRST state, then responds with rsp_err=0.
- Undefined: NRST and its counter are absent; ijtag_net_reset_n is tied 1; op=RESET responds with rsp_err=1 and no network activity.

Decomposition:
- Package firebird7_in_ijtag_drv_pkg holds:
  - FSM state enum (IDLE, CAP, SHIFT, UPD, NRST, RESP).
  - cmd_op encodings.
  - Default MAX_LEN and RST_CYCLES constants.
- One sub-module, firebird7_in_ijtag_drv_outstage: negedge output register bank for sel/ce/se/ue/si/net_reset_n, with asynchronous reset.

Test Plan:
- Single SIB, initially closed (sel path 1 bit): SCAN len=1, data=1 -> rsp_data[0]=0 (capture clears the SIB). After UPD the SIB opens and its ijtag_to_sel=1 from the second negedge after ue.
- Open SIB plus an 8-bit TDR behind it: SCAN len=9, data=0x1A5 -> rsp_data shows the 0x00 previously loaded plus the SIB bit. A second identical SCAN returns 0x1A5 masked by the TDR capture values.
- len=0: exactly one ce cycle and one ue cycle, zero se cycles; rsp_data=0, rsp_err=0.
- len=MAX_LEN+1 -> rsp_err=1, ijtag_sel stays 0 throughout. RESET command with the macro undefined -> rsp_err=1.
- ijtag_reset pulled low during SHIFT cycle 3 of a len=16 scan -> all controls 0 by the next negedge, no rsp_valid. After release, cmd_ready=1 and a new scan completes normally.
- rsp_ready held 0 for 10 cycles: rsp_valid and rsp_data stay stable, cmd_ready=0, no network activity. With the macro defined, RESET gives ijtag_net_reset_n=0 for exactly 4 cycles.

Source files
------------

// File: rtl/firebird7_in_ijtag_drv_pkg.sv
// Shared constants, state codes and control-bundle type for the firebird7_in IJTAG scan driver.
// The network-reset command is enabled by FIREBIRD7_IN_IJTAG_DRV_NET_RESET_EN.
package firebird7_in_ijtag_drv_pkg;

  localparam int DEF_MAX_LEN    = 64;
  localparam int DEF_RST_CYCLES = 4;

  localparam logic OP_SCAN  = 1'b0;
  localparam logic OP_RESET = 1'b1;

  typedef logic [2:0] drv_state_t;

  localparam drv_state_t ST_IDLE  = 3'd0;
  localparam drv_state_t ST_CAP   = 3'd1;
  localparam drv_state_t ST_SHIFT = 3'd2;
  localparam drv_state_t ST_UPD   = 3'd3;
  localparam drv_state_t ST_NRST  = 3'd4;
  localparam drv_state_t ST_RESP  = 3'd5;

  typedef struct packed {
    logic sel;
    logic ce;
    logic se;
    logic ue;
    logic si;
    logic net_reset_n;
  } ijtag_ctrl_t;

  // Quiet network: nothing selected, network reset released.
  localparam ijtag_ctrl_t CTRL_QUIET = '{sel: 1'b0, ce: 1'b0, se: 1'b0, ue: 1'b0,
                                         si: 1'b0, net_reset_n: 1'b1};

endpackage

// File: rtl/firebird7_in_ijtag_drv_outstage.sv
// Negedge output register bank for the IJTAG control pins, so every control value
// is stable across the following posedge (capture/shift) and negedge (update latch).
module firebird7_in_ijtag_drv_outstage
  import firebird7_in_ijtag_drv_pkg::*;
(
  input  logic        ijtag_tck,
  input  logic        ijtag_reset,
  input  ijtag_ctrl_t ctrl_d,
  output logic        ijtag_sel,
  output logic        ijtag_ce,
  output logic        ijtag_se,
  output logic        ijtag_ue,
  output logic        ijtag_si,
  output logic        ijtag_net_reset_n
);

  ijtag_ctrl_t ctrl_q;

  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      ctrl_q <= CTRL_QUIET;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  assign ijtag_sel         = ctrl_q.sel;
  assign ijtag_ce          = ctrl_q.ce;
  assign ijtag_se          = ctrl_q.se;
  assign ijtag_ue          = ctrl_q.ue;
  assign ijtag_si          = ctrl_q.si;
  assign ijtag_net_reset_n = ctrl_q.net_reset_n;

endmodule

// File: rtl/firebird7_in_ijtag_scan_driver.sv
// IJTAG initiator: one capture-shift-update sequence per command, returning the so bits.
// Define FIREBIRD7_IN_IJTAG_DRV_NET_RESET_EN to enable the network-reset (op=RESET) command.
module firebird7_in_ijtag_scan_driver
  import firebird7_in_ijtag_drv_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
`ifdef FIREBIRD7_IN_IJTAG_DRV_NET_RESET_EN
  ,
  parameter int RST_CYCLES = DEF_RST_CYCLES
`endif
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so,
  output logic               ijtag_net_reset_n
);

  drv_state_t         state;
  logic               run_q;
  logic [LEN_W-1:0]   shift_cnt;
  logic [LEN_W-1:0]   samp_idx;
  logic [MAX_LEN-1:0] shift_reg;
  logic [MAX_LEN-1:0] cap_reg;
  logic               err_q;
  logic               accept;
  ijtag_ctrl_t        ctrl_d;

`ifdef FIREBIRD7_IN_IJTAG_DRV_NET_RESET_EN
  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  logic [RST_W-1:0] rst_cnt;
`endif

  // run_q keeps cmd_ready low while reset is asserted and for the first edge after release.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  assign cmd_ready = run_q && (state == ST_IDLE);
  assign accept    = cmd_ready && cmd_valid;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_data  = rsp_valid ? cap_reg : '0;

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state     <= ST_IDLE;
      shift_cnt <= '0;
      shift_reg <= '0;
      err_q     <= 1'b0;
`ifdef FIREBIRD7_IN_IJTAG_DRV_NET_RESET_EN
      rst_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            err_q <= 1'b0;
            if (cmd_op == OP_RESET) begin
`ifdef FIREBIRD7_IN_IJTAG_DRV_NET_RESET_EN
              rst_cnt <= RST_W'(RST_CYCLES - 1);
              state   <= ST_NRST;
`else
              err_q <= 1'b1;
              state <= ST_RESP;
`endif
            end else if (cmd_len > LEN_W'(MAX_LEN)) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else begin
              shift_cnt <= cmd_len;
              shift_reg <= cmd_data;
              state     <= ST_CAP;
            end
          end
        end
        ST_CAP: begin
          state <= (shift_cnt != '0) ? ST_SHIFT : ST_UPD;
        end
        ST_SHIFT: begin
          shift_reg <= {1'b0, shift_reg[MAX_LEN-1:1]};
          shift_cnt <= shift_cnt - LEN_W'(1);
          if (shift_cnt == LEN_W'(1)) begin
            state <= ST_UPD;
          end
        end
        ST_UPD: begin
          state <= ST_RESP;
        end
`ifdef FIREBIRD7_IN_IJTAG_DRV_NET_RESET_EN
        ST_NRST: begin
          rst_cnt <= rst_cnt - RST_W'(1);
          if (rst_cnt == '0) begin
            state <= ST_RESP;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sampling follows the registered se pin, not the FSM, so sample k lines up with shift k.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      cap_reg  <= '0;
      samp_idx <= '0;
    end else if (accept) begin
      cap_reg  <= '0;
      samp_idx <= '0;
    end else if (ijtag_se) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (samp_idx == LEN_W'(i)) begin
          cap_reg[i] <= ijtag_so;
        end
      end
      samp_idx <= samp_idx + LEN_W'(1);
    end
  end

  always_comb begin
    ctrl_d = CTRL_QUIET;
    case (state)
      ST_CAP: begin
        ctrl_d.sel = 1'b1;
        ctrl_d.ce  = 1'b1;
      end
      ST_SHIFT: begin
        ctrl_d.sel = 1'b1;
        ctrl_d.se  = 1'b1;
        ctrl_d.si  = shift_reg[0];
      end
      ST_UPD: begin
        ctrl_d.sel = 1'b1;
        ctrl_d.ue  = 1'b1;
      end
`ifdef FIREBIRD7_IN_IJTAG_DRV_NET_RESET_EN
      ST_NRST: begin
        ctrl_d.net_reset_n = 1'b0;
      end
`endif
      default: begin
        ctrl_d = CTRL_QUIET;
      end
    endcase
  end

  firebird7_in_ijtag_drv_outstage u_outstage (
    .ijtag_tck         (ijtag_tck),
    .ijtag_reset       (ijtag_reset),
    .ctrl_d            (ctrl_d),
    .ijtag_sel         (ijtag_sel),
    .ijtag_ce          (ijtag_ce),
    .ijtag_se          (ijtag_se),
    .ijtag_ue          (ijtag_ue),
    .ijtag_si          (ijtag_si),
    .ijtag_net_reset_n (ijtag_net_reset_n)
  );

endmodule
